// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and helpers for the RV32I pipeline stages
package pipe_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] wb, input logic [31:0] mem);
    return (sel == FWD_WB) ? wb : (sel == FWD_MEM) ? mem : rf;
  endfunction
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational 32-bit ALU with zero detect
module exec_alu
  import pipe_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  ALUControl,
  output logic [31:0] ALUResult,
  output logic        Zero
);
  always_comb begin
    ALUResult = (ALUControl == ALU_ADD) ? SrcA + SrcB :
                (ALUControl == ALU_SUB) ? SrcA - SrcB :
                (ALUControl == ALU_OR)  ? SrcA | SrcB :
                (ALUControl == ALU_AND) ? SrcA & SrcB :
                (ALUControl == ALU_SLT) ? {31'd0, $signed(SrcA) < $signed(SrcB)} : 32'd0;
    Zero = (ALUResult == 32'd0);
  end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: forwarding, ALU, branch resolution, wrong-path squash and E/M register
module execute_cycle
  import pipe_pkg::*;
#(
  parameter int KILL_SLOTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RD_M,
  output logic        SquashE
);
  localparam logic [1:0] KILL_INIT = 2'(KILL_SLOTS);
  logic [31:0] src_a, fwd_b, src_b, alu_result;
  logic        zero;
  logic [1:0]  kill_cnt;
  always_comb begin
    src_a = fwd_mux(ForwardAE, RD1_E, ResultW, ALUResultM);
    fwd_b = fwd_mux(ForwardBE, RD2_E, ResultW, ALUResultM);
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end
  exec_alu u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .ALUResult  (alu_result),
    .Zero       (zero)
  );
  // a squashed branch must never redirect, so the squash gates the redirect itself
  assign SquashE   = (kill_cnt != 2'd0);
  assign PCSrcE    = ~SquashE & ((BranchE & zero) | JumpE);
  assign PCTargetE = PCE + Imm_Ext_E;
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_cnt   <= 2'd0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= RES_ALU;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
      RD_M       <= 5'd0;
    end else begin
      kill_cnt   <= PCSrcE ? KILL_INIT : SquashE ? kill_cnt - 2'd1 : kill_cnt;
      RegWriteM  <= RegWriteE & ~SquashE;
      MemWriteM  <= MemWriteE & ~SquashE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
      RD_M       <= RD_E;
    end
  end
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed scoreboard bench for the execute stage
module tb_execute_cycle;
  typedef struct {
    logic        reg_w;
    logic        mem_w;
    logic [1:0]  res;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, RegWriteM, MemWriteM, SquashE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  execute_cycle #(.KILL_SLOTS(2)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RD_M(RD_M),
    .SquashE(SquashE)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE} = '0;
    ResultSrcE = 2'b00; ALUControlE = 3'b000; ForwardAE = 2'b00; ForwardBE = 2'b00;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0;
  endtask
  task automatic tick(input string tag, input logic pcs, input logic sq, input logic [31:0] tgt,
                      input logic rw, input logic mw, input logic [1:0] res, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
    exp_t e;
    #1;
    chk({tag, ".PCSrcE"}, 32'(PCSrcE), 32'(pcs));
    chk({tag, ".SquashE"}, 32'(SquashE), 32'(sq));
    chk({tag, ".PCTargetE"}, PCTargetE, tgt);
    e = '{rw, mw, res, alu, wd, pc4, rd};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".RegWriteM"}, 32'(RegWriteM), 32'(e.reg_w));
      chk({tag, ".MemWriteM"}, 32'(MemWriteM), 32'(e.mem_w));
      chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'(e.res));
      chk({tag, ".ALUResultM"}, ALUResultM, e.alu);
      chk({tag, ".WriteDataM"}, WriteDataM, e.wd);
      chk({tag, ".PCPlus4M"}, PCPlus4M, e.pc4);
      chk({tag, ".RD_M"}, 32'(RD_M), 32'(e.rd));
    end
  endtask
  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.RegWriteM", 32'(RegWriteM), 0);
    chk("reset.MemWriteM", 32'(MemWriteM), 0);
    chk("reset.ALUResultM", ALUResultM, 0);
    chk("reset.RD_M", 32'(RD_M), 0);
    chk("reset.SquashE", 32'(SquashE), 0);
    rst = 1'b0;
    clr(); RD1_E = 5; RD2_E = 7; RegWriteE = 1; RD_E = 3; PCPlus4E = 8;
    tick("add", 0, 0, 0, 1, 0, 2'b00, 12, 7, 8, 3);
    clr(); ALUControlE = 3'b001; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 4;
    RD1_E = 100; RD2_E = 200; RegWriteE = 1; RD_E = 5;
    tick("fwd_sub", 0, 0, 0, 1, 0, 2'b00, 8, 4, 0, 5);
    clr(); ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    tick("slt_neg", 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
    clr(); ALUControlE = 3'b101; RD1_E = 1; RD2_E = 32'hFFFF_FFFF;
    tick("slt_swap", 0, 0, 0, 0, 0, 2'b00, 0, 32'hFFFF_FFFF, 0, 0);
    clr(); ALUControlE = 3'b011; ALUSrcE = 1; RD1_E = 32'hF0; RD2_E = 32'h55; Imm_Ext_E = 32'h0F;
    tick("or_imm", 0, 0, 32'h0F, 0, 0, 2'b00, 32'hFF, 32'h55, 0, 0);
    clr(); ALUControlE = 3'b100; ForwardAE = 2'b11; ForwardBE = 2'b11; RD1_E = 32'hF0; RD2_E = 32'h3C;
    ResultW = 32'hFFFF_FFFF;
    tick("and_fwd11", 0, 0, 0, 0, 0, 2'b00, 32'h30, 32'h3C, 0, 0);
    clr(); ALUControlE = 3'b110; RD1_E = 32'h1234; RD2_E = 32'h5678;
    tick("undef_op", 0, 0, 0, 0, 0, 2'b00, 0, 32'h5678, 0, 0);
    clr(); ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; BranchE = 1; PCE = 32'h40; Imm_Ext_E = 32'h10;
    tick("beq_taken", 1, 0, 32'h50, 0, 0, 2'b00, 0, 9, 0, 0);
    clr(); ALUControlE = 3'b001; RD1_E = 3; RD2_E = 3; BranchE = 1; RegWriteE = 1; MemWriteE = 1; RD_E = 7;
    tick("shadow_beq", 0, 1, 0, 0, 0, 2'b00, 0, 3, 0, 7);
    clr(); RD1_E = 1; RD2_E = 2; RegWriteE = 1; MemWriteE = 1; RD_E = 8;
    tick("shadow2", 0, 1, 0, 0, 0, 2'b00, 3, 2, 0, 8);
    clr(); RD1_E = 32'h10; RD2_E = 32'h20; RegWriteE = 1; MemWriteE = 1; RD_E = 9;
    tick("commit", 0, 0, 0, 1, 1, 2'b00, 32'h30, 32'h20, 0, 9);
    clr(); JumpE = 1; RegWriteE = 1; ResultSrcE = 2'b10; PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0;
    PCPlus4E = 32'h104; RD_E = 1;
    tick("jal", 1, 0, 32'hF0, 1, 0, 2'b10, 0, 0, 32'h104, 1);
    clr(); RD1_E = 7; RegWriteE = 1; MemWriteE = 1; RD_E = 2; rst = 1;
    tick("rst_mid", 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    rst = 0;
    clr(); RD1_E = 7; RD2_E = 1; RegWriteE = 1; RD_E = 2;
    tick("post_rst", 0, 0, 0, 1, 0, 2'b00, 8, 1, 0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RV32I pipeline. It sits directly downstream of the decode stage's D/E register and consumes its outputs: the E-side control signals, operands, immediate, PC values and register indices. It applies the hazard unit's forwarding selects, runs the ALU and resolves branches and jumps. It also squashes wrong-path instructions after a taken redirect, then registers the results into the E/M pipeline register feeding the memory stage.

## Interface
Parameters:
- KILL_SLOTS, 2, number of instructions entering E after a taken redirect that are squashed (1..3).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  in  1 each  control from D/E register; JumpE is tied 0 until decode drives it.
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  in  3  000 ADD, 001 SUB, 011 OR, 100 AND, 101 SLT (signed).
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate and PCs.
- RD_E  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  operand select: 00 register file, 01 ResultW, 10 ALUResultM; 11 behaves as 00.
- ResultW  in  32  writeback result for forwarding.
- PCSrcE  out  1  taken redirect, combinational.
- PCTargetE  out  32  PCE + Imm_Ext_E, combinational.
- RegWriteM, MemWriteM  out  1 each  registered control.
- ResultSrcM  out  2  registered.
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered.
- RD_M  out  5  registered.
- SquashE  out  1  current E instruction is being squashed, combinational.

## Operation
- SrcA is selected from RD1_E, ResultW or ALUResultM by ForwardAE.
- The forwarded B value is selected from RD2_E, ResultW or ALUResultM by ForwardBE. It becomes WriteDataM.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- ALU is 32-bit with wrap-around add/sub and no overflow flag.
  - SLT gives 1 when $signed(SrcA) < $signed(SrcB), else 0.
  - Undefined ALUControlE codes give 0.
- ZeroE = (ALUResult == 0).
- PCSrcE = ~SquashE & ((BranchE & ZeroE) | JumpE).
- PCTargetE = PCE + Imm_Ext_E, 32-bit wrap. It is valid regardless of PCSrcE.
- Kill counter kill_cnt: 2 bits, reset 0. SquashE = (kill_cnt != 0).
  - When PCSrcE is 1: kill_cnt <= KILL_SLOTS.
  - Else, when kill_cnt != 0: kill_cnt <= kill_cnt - 1.
  - PCSrcE cannot assert while squashing, so a squashed branch never reloads the counter.
- E/M register:
  - RegWriteM <= RegWriteE & ~SquashE.
  - MemWriteM <= MemWriteE & ~SquashE.
  - All other fields load unconditionally; their contents are don't-care when squashed.
- A squashed instruction is a bubble. It writes nothing and stores nothing, so it cannot corrupt state.

## Timing
- Reset (rst high at a clock edge):
  - RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RD_M all become 0.
  - kill_cnt becomes 0, so SquashE = 0 in the next cycle.
- Reset mid-squash clears kill_cnt immediately. No squash survives reset.
- PCSrcE and PCTargetE are valid in the same cycle the branch occupies E, with zero latency to fetch.
- E/M register latency is 1 cycle.
- After a taken redirect in cycle t, the instructions occupying E in cycles t+1 .. t+KILL_SLOTS are squashed. The instruction in E at t+KILL_SLOTS+1 executes normally.
- Back-to-back branches: the second is in the shadow and is squashed. No redirect occurs.
- ForwardAE/BE = 10 uses the current ALUResultM register output, i.e. the prior instruction.

## Structure
- Shared package pipe_pkg holds:
  - ALU opcode constants (ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SLT);
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4);
  - forward-select encodings (FWD_RF, FWD_WB, FWD_MEM).
- Decode's ALU decoder and the hazard unit import the same package.
- One sub-module: exec_alu. It is purely combinational, with inputs SrcA, SrcB and ALUControl, and outputs ALUResult and Zero.
- Forwarding muxes, branch logic, kill counter and the E/M register stay in execute_cycle.

## Test plan
- ADD, no forwarding: RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000, RegWriteE=1, RD_E=3 -> next cycle ALUResultM=12, RD_M=3, RegWriteM=1.
- Forwarding: ForwardAE=10 with ALUResultM=12, ForwardBE=01 with ResultW=4, SUB -> ALUResultM=8, WriteDataM=4.
- SLT signed: SrcA=0xFFFFFFFF, SrcB=1 -> ALUResultM=1. Swapped operands -> 0.
- Taken BEQ: RD1_E=RD2_E=9, BranchE=1, PCE=0x40, Imm_Ext_E=0x10 -> PCSrcE=1, PCTargetE=0x50 same cycle. The next two E instructions (RegWriteE=1 and MemWriteE=1) give RegWriteM=MemWriteM=0. The third commits.
- Branch in shadow: a taken-condition BEQ arriving one cycle after a taken branch -> PCSrcE=0 and kill_cnt not reloaded.
- Reset mid-squash: assert rst one cycle after a taken branch -> all M outputs 0. The following instruction, with RegWriteE=1, commits RegWriteM=1.
